// File: rtl/dmem_arbiter.sv
// Data-memory arbiter shared by the pipeline MEM stage and a DMA/debug port.
// The pipeline normally has priority. A starvation counter forces one DMA
// grant after STARVE_MAX consecutive denied DMA cycles. The grant decision is
// combinational, so at most one memory access happens per cycle.
// DMA read data and the owner record are registered.
module dmem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_req,
    input  logic        p_we,
    input  logic [31:0] p_addr,
    input  logic [31:0] p_wdata,
    output logic [31:0] p_rdata,
    output logic        p_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_memwrite,
    output logic        m_memread,
    input  logic [31:0] m_rdata,
    output logic [1:0]  owner
);

    typedef enum logic [1:0] {
        OWN_IDLE   = 2'b00,
        OWN_PIPE   = 2'b01,
        OWN_DMA    = 2'b10,
        OWN_FORCED = 2'b11
    } owner_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]  r_starve_cnt;
    logic        r_d_valid;
    logic [31:0] r_d_rdata;
    owner_t      r_owner;

    logic w_force;
    logic w_dma_win;
    logic w_pipe_win;

    // While reset is low neither port may win, so every strobe stays low.
    assign w_force    = d_req && (r_starve_cnt == STARVE_LIM);
    assign w_dma_win  = reset && d_req && (w_force || !p_req);
    assign w_pipe_win = reset && p_req && !w_dma_win;

    // Steer the winning port onto the memory bus. With no winner the bus is zero.
    always_comb begin
        m_addr     = 32'h0;
        m_wdata    = 32'h0;
        m_memwrite = 1'b0;
        m_memread  = 1'b0;
        p_rdata    = 32'h0;
        if (w_dma_win) begin
            m_addr     = d_addr;
            m_wdata    = d_wdata;
            m_memwrite = d_we;
            m_memread  = !d_we;
        end else if (w_pipe_win) begin
            m_addr     = p_addr;
            m_wdata    = p_wdata;
            m_memwrite = p_we;
            m_memread  = !p_we;
            if (!p_we) begin
                p_rdata = m_rdata;
            end
        end
    end

    assign d_gnt   = w_dma_win;
    assign p_stall = w_dma_win && p_req;
    assign d_valid = r_d_valid;
    assign d_rdata = r_d_rdata;
    assign owner   = r_owner;

    // Update the starvation counter, capture DMA read data, and record the owner.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_starve_cnt <= 4'h0;
            r_d_valid    <= 1'b0;
            r_d_rdata    <= 32'h0;
            r_owner      <= OWN_IDLE;
        end else begin
            if (d_req && !w_dma_win) begin
                if (r_starve_cnt < STARVE_LIM) begin
                    r_starve_cnt <= r_starve_cnt + 4'h1;
                end
            end else begin
                r_starve_cnt <= 4'h0;
            end

            if (w_dma_win && !d_we) begin
                r_d_rdata <= m_rdata;
                r_d_valid <= 1'b1;
            end else begin
                r_d_valid <= 1'b0;
            end

            if (w_dma_win && w_force) begin
                r_owner <= OWN_FORCED;
            end else if (w_dma_win) begin
                r_owner <= OWN_DMA;
            end else if (w_pipe_win) begin
                r_owner <= OWN_PIPE;
            end else begin
                r_owner <= OWN_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. A stateful vector table drives the
// STARVE_MAX=4 instance. A hand-written sequence checks the STARVE_MAX=1
// alternation on a second instance.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        p_req, p_we, d_req, d_we;
    logic [31:0] p_addr, p_wdata, d_addr, d_wdata;
    logic [31:0] p_rdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic        p_stall, d_gnt, d_valid, m_memwrite, m_memread;
    logic [1:0]  owner;

    logic        q_p_req, q_p_we, q_d_req, q_d_we;
    logic [31:0] q_p_addr, q_p_wdata, q_d_addr, q_d_wdata;
    logic [31:0] q_p_rdata, q_d_rdata, q_m_addr, q_m_wdata, q_m_rdata;
    logic        q_p_stall, q_d_gnt, q_d_valid, q_m_memwrite, q_m_memread;
    logic [1:0]  q_owner;

    logic [31:0] mem [0:15];

    int n_checks = 0;
    int n_errors = 0;

    dmem_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_stall(p_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_valid(d_valid),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_memwrite(m_memwrite),
        .m_memread(m_memread), .m_rdata(m_rdata), .owner(owner)
    );

    dmem_arbiter #(.STARVE_MAX(1)) dut1 (
        .clk(clk), .reset(reset),
        .p_req(q_p_req), .p_we(q_p_we), .p_addr(q_p_addr), .p_wdata(q_p_wdata),
        .p_rdata(q_p_rdata), .p_stall(q_p_stall),
        .d_req(q_d_req), .d_we(q_d_we), .d_addr(q_d_addr), .d_wdata(q_d_wdata),
        .d_gnt(q_d_gnt), .d_rdata(q_d_rdata), .d_valid(q_d_valid),
        .m_addr(q_m_addr), .m_wdata(q_m_wdata), .m_memwrite(q_m_memwrite),
        .m_memread(q_m_memread), .m_rdata(q_m_rdata), .owner(q_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational-read memory model for the main instance.
    assign m_rdata = mem[m_addr[3:0]];
    always @(posedge clk) begin
        if (m_memwrite) mem[m_addr[3:0]] <= m_wdata;
    end

    // Fixed pattern memory for the STARVE_MAX=1 instance.
    assign q_m_rdata = q_m_addr ^ 32'h5A5A_0000;

    typedef struct {
        logic        rst, preq, pwe;
        logic [31:0] paddr, pwdata;
        logic        dreq, dwe;
        logic [31:0] daddr, dwdata;
        logic        gnt, stall, mw, mr;
        logic [31:0] maddr, mwdata, prdata;
        logic [1:0]  own;
        logic        dv;
        logic [31:0] drd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        logic rst, logic preq, logic pwe, logic [31:0] paddr, logic [31:0] pwdata,
        logic dreq, logic dwe, logic [31:0] daddr, logic [31:0] dwdata,
        logic gnt, logic stall, logic mw, logic mr,
        logic [31:0] maddr, logic [31:0] mwdata, logic [31:0] prdata,
        logic [1:0] own, logic dv, logic [31:0] drd);
        vec_t v;
        v.rst = rst; v.preq = preq; v.pwe = pwe; v.paddr = paddr; v.pwdata = pwdata;
        v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwdata = dwdata;
        v.gnt = gnt; v.stall = stall; v.mw = mw; v.mr = mr;
        v.maddr = maddr; v.mwdata = mwdata; v.prdata = prdata;
        v.own = own; v.dv = dv; v.drd = drd;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // Contention building blocks: pipeline reads 0x0A (holds 0x1100), DMA reads 0x0C.
    function automatic vec_t pipe_win(logic [31:0] drd);
        return mk(1, 1, 0, 32'h0A, 32'h0, 1, 0, 32'h0C, 32'h0,
                  0, 0, 0, 1, 32'h0A, 32'h0, 32'h1100, 2'd1, 0, drd);
    endfunction

    function automatic vec_t forced_win();
        return mk(1, 1, 0, 32'h0A, 32'h0, 1, 0, 32'h0C, 32'h0,
                  1, 1, 0, 1, 32'h0C, 32'h0, 32'h0, 2'd3, 1, 32'h2222);
    endfunction

    initial begin
        vec_t v;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[11] = 32'h1111;

        q_p_req = 0; q_p_we = 0; q_p_addr = 32'h1; q_p_wdata = 0;
        q_d_req = 0; q_d_we = 0; q_d_addr = 32'h3; q_d_wdata = 0;

        // Reset with both ports requesting: nothing may be granted.
        vecs.push_back(mk(0, 1, 1, 32'h0A, 32'h55, 1, 0, 32'h0B, 32'h0, 0,0,0,0, 0,0,0, 2'd0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h0A, 32'h55, 1, 0, 32'h0B, 32'h0, 0,0,0,0, 0,0,0, 2'd0, 0, 0));
        // Idle.
        vecs.push_back(mk(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0,0,0,0, 0,0,0, 2'd0, 0, 0));
        // Pipeline store, then load back.
        vecs.push_back(mk(1, 1, 1, 32'h0A, 32'h1100, 0, 0, 32'h0, 32'h0, 0,0,1,0, 32'h0A,32'h1100,0, 2'd1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0A, 32'h1100, 0, 0, 32'h0, 32'h0, 0,0,0,1, 32'h0A,32'h1100,32'h1100, 2'd1, 0, 0));
        // DMA-only read of 0x0B.
        vecs.push_back(mk(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0B, 32'h0, 1,0,0,1, 32'h0B,0,0, 2'd2, 1, 32'h1111));
        // Idle: d_valid drops, d_rdata holds.
        vecs.push_back(mk(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0,0,0,0, 0,0,0, 2'd0, 0, 32'h1111));
        // DMA write to 0x0C: no d_valid.
        vecs.push_back(mk(1, 0, 0, 32'h0, 32'h0, 1, 1, 32'h0C, 32'h2222, 1,0,1,0, 32'h0C,32'h2222,0, 2'd2, 0, 32'h1111));
        // Pipeline reads back the DMA write.
        vecs.push_back(mk(1, 1, 0, 32'h0C, 32'h0, 0, 0, 32'h0, 32'h0, 0,0,0,1, 32'h0C,0,32'h2222, 2'd1, 0, 32'h1111));
        // Continuous contention: 4 pipeline wins, then a forced grant, twice.
        for (int i = 0; i < 4; i++) vecs.push_back(pipe_win(32'h1111));
        vecs.push_back(forced_win());
        for (int i = 0; i < 4; i++) vecs.push_back(pipe_win(32'h2222));
        vecs.push_back(forced_win());
        // Three denied cycles, then d_req drops, which clears the counter.
        for (int i = 0; i < 3; i++) vecs.push_back(pipe_win(32'h2222));
        vecs.push_back(mk(1, 1, 0, 32'h0A, 32'h0, 0, 0, 32'h0C, 32'h0, 0,0,0,1, 32'h0A,0,32'h1100, 2'd1, 0, 32'h2222));
        for (int i = 0; i < 4; i++) vecs.push_back(pipe_win(32'h2222));
        vecs.push_back(forced_win());
        // Reset lands on the would-be forced cycle.
        for (int i = 0; i < 4; i++) vecs.push_back(pipe_win(32'h2222));
        vecs.push_back(mk(0, 1, 0, 32'h0A, 32'h0, 1, 0, 32'h0C, 32'h0, 0,0,0,0, 0,0,0, 2'd0, 0, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(pipe_win(32'h0));
        vecs.push_back(forced_win());
        // Idle.
        vecs.push_back(mk(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0,0,0,0, 0,0,0, 2'd0, 0, 32'h2222));

        foreach (vecs[i]) begin
            v = vecs[i];
            @(negedge clk);
            reset = v.rst; p_req = v.preq; p_we = v.pwe; p_addr = v.paddr; p_wdata = v.pwdata;
            d_req = v.dreq; d_we = v.dwe; d_addr = v.daddr; d_wdata = v.dwdata;
            #1;
            chk("d_gnt", i, 32'(d_gnt), 32'(v.gnt));
            chk("p_stall", i, 32'(p_stall), 32'(v.stall));
            chk("m_memwrite", i, 32'(m_memwrite), 32'(v.mw));
            chk("m_memread", i, 32'(m_memread), 32'(v.mr));
            chk("m_addr", i, m_addr, v.maddr);
            chk("m_wdata", i, m_wdata, v.mwdata);
            chk("p_rdata", i, p_rdata, v.prdata);
            @(posedge clk);
            #1;
            chk("owner", i, 32'(owner), 32'(v.own));
            chk("d_valid", i, 32'(d_valid), 32'(v.dv));
            chk("d_rdata", i, d_rdata, v.drd);
        end

        // STARVE_MAX=1: under continuous contention the DMA port wins every second cycle.
        @(negedge clk);
        q_p_req = 1; q_d_req = 1;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            chk("sm1 d_gnt", i, 32'(q_d_gnt), (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("sm1 p_stall", i, 32'(q_p_stall), (i % 2 == 1) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
            chk("sm1 owner", i, 32'(q_owner), (i % 2 == 1) ? 32'd3 : 32'd1);
            chk("sm1 d_valid", i, 32'(q_d_valid), (i % 2 == 1) ? 32'd1 : 32'd0);
        end
        chk("sm1 d_rdata", 6, q_d_rdata, 32'h5A5A_0003);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, is the number of consecutive denied DMA-port cycles before that port is forced a grant; legal range 1..15.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 p_req  in  1  pipeline MEM-stage access request (memread|memwrite).
REQ-005 p_we  in  1  pipeline write enable (1 = store, 0 = load).
REQ-006 p_addr / p_wdata  in  32 / 32  pipeline address / store data.
REQ-007 p_rdata  out  32  load data to the MEM stage.
REQ-008 p_stall  out  1  pipeline must hold MEM-stage inputs this cycle.
REQ-009 d_req / d_we  in  1 / 1  DMA/debug-port request / write enable.
REQ-010 d_addr / d_wdata  in  32 / 32  DMA-port address / write data.
REQ-011 d_gnt  out  1  DMA access performed this cycle.
REQ-012 d_rdata / d_valid  out  32 / 1  registered DMA read data / one-cycle valid pulse.
REQ-013 m_addr / m_wdata  out  32 / 32  data-memory address / write data.
REQ-014 m_memwrite / m_memread  out  1 / 1  data-memory strobes.
REQ-015 m_rdata  in  32  data-memory read data, combinational from m_addr.
REQ-016 owner  out  2  registered grant record: 00 IDLE, 01 PIPE, 10 DMA, 11 FORCED.

Function
REQ-017 Grant decision is combinational each cycle from p_req, d_req and starve_cnt; one access per cycle maximum.
REQ-018 Forced grant: d_req=1 and starve_cnt==STARVE_MAX -> DMA port wins regardless of p_req.
REQ-019 Otherwise p_req=1 -> pipeline wins; else d_req=1 -> DMA port wins; else no access.
REQ-020 Winner's addr/wdata drive m_addr/m_wdata; m_memwrite = winner's we; m_memread = ~winner's we.
REQ-021 No access -> m_memwrite=0, m_memread=0, m_addr=0, m_wdata=0.
REQ-022 p_stall=1 exactly when p_req=1 and the DMA port wins.
REQ-023 p_rdata = m_rdata when pipeline wins with p_we=0; else 0.
REQ-024 d_gnt=1 exactly when the DMA port wins.
REQ-025 starve_cnt (4 bits): increments by 1 when d_req=1 and d_gnt=0; saturates at STARVE_MAX; clears to 0 when d_gnt=1 or d_req=0.
REQ-026 d_gnt=1 and d_we=0 -> next edge: d_rdata<=m_rdata, d_valid<=1; otherwise d_valid<=0 and d_rdata holds.
REQ-027 owner next-state: no access -> IDLE; pipeline -> PIPE; DMA normal -> DMA; DMA via REQ-018 -> FORCED.
REQ-028 DMA port write completes in its grant cycle; no d_valid for writes.
REQ-029 Stalled pipeline keeps p_req/p_we/p_addr/p_wdata stable; block does not latch pipeline requests.
REQ-030 Back-to-back forced grants impossible: counter is 0 after any grant, so pipeline wins at least the next STARVE_MAX contended cycles.
REQ-031 STARVE_MAX=1 -> DMA wins every second contended cycle.

Reset
REQ-032 While reset=0 at an edge: starve_cnt<=0, d_valid<=0, d_rdata<=0, owner<=IDLE.
REQ-033 While reset=0: d_gnt=0, p_stall=0, m_memwrite=0, m_memread=0, p_rdata=0 regardless of requests.
REQ-034 Reset asserted mid-contention discards the pending starve count; first cycle after release arbitrates from starve_cnt=0.

Verification
REQ-035 Pipeline-only: p_req=1, p_we=1, p_addr=0x0A, p_wdata=0x1100, then p_we=0 -> m_memwrite pulse, then p_rdata=0x1100, p_stall=0, owner PIPE.
REQ-036 DMA-only: d_req=1, d_we=0, d_addr=0x0B, memory holds 0x1111 -> d_gnt=1 same cycle, d_valid=1 and d_rdata=0x1111 next cycle, owner DMA.
REQ-037 Contention, STARVE_MAX=4: p_req=d_req=1 continuously -> pipeline wins 4 cycles, 5th cycle d_gnt=1, p_stall=1, owner FORCED; repeats every 5 cycles.
REQ-038 Contention with d_req dropped at starve_cnt=3 -> counter clears; reassertion needs 4 more denied cycles before forced grant.
REQ-039 Reset low during forced-grant cycle -> d_gnt=0, p_stall=0, strobes 0; after release d_valid=0, owner IDLE, counter restarts from 0.
REQ-040 Idle: both req=0 -> all m_* outputs 0, owner IDLE, d_valid 0.
